// File: rtl/cluster_frame_builder_if.sv
// Port bundle for the cluster frame builder: per-BX cluster inputs in, link word and status out.
interface cluster_frame_builder_if;
    logic              frame_strobe;
    logic              bc0;
    logic [7:0][10:0]  adr;
    logic [7:0][2:0]   cnt;
    logic [15:0]       link_data;
    logic              link_k;
    logic              overflow;
    logic              sync_err;
    logic [15:0]       drop_cnt;

    modport master (
        output frame_strobe, bc0, adr, cnt,
        input  link_data, link_k, overflow, sync_err, drop_cnt
    );

    modport slave (
        input  frame_strobe, bc0, adr, cnt,
        output link_data, link_k, overflow, sync_err, drop_cnt
    );
endinterface

// File: rtl/cluster_frame_builder.sv
// Packs each BX's valid clusters into header + cluster words, queues them and drains one word per clock4x.
// Optional feature: define FRAMER_DROP_COUNTER_EN to build the saturating dropped-BX counter.
module cluster_frame_builder #(
    parameter int          FIFO_AW   = 5,
    parameter logic [15:0] IDLE_WORD = 16'h50BC
) (
    input  logic clock4x,
    input  logic global_reset,
    cluster_frame_builder_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;
    state_t state_reg, state_next;

    logic [7:0]        valid;
    logic [7:0][15:0]  cluster_word;
    logic [7:0][3:0]   pos;
    logic [7:0][15:0]  stage_cap;
    logic [3:0]        n_cnt;
    logic              trunc;

    logic [7:0][15:0]  stage_reg;
    logic [2:0]        idx_reg, idx_next;
    logic [3:0]        n_reg;
    logic [7:0]        bxn_reg;
    logic              ovf_pend_reg, overflow_reg, sync_err_reg;

    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [15:0]        link_data_reg;
    logic               link_k_reg;

    logic        wr_en, hdr_wr, drop, sync_hit, pop;
    logic [15:0] wr_data, free_words, needed, header;
    logic [7:0]  hdr_bxn;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cluster
            assign valid[gi]        = bus.adr[gi] < 11'd1536;
            assign cluster_word[gi] = {2'b00, bus.cnt[gi], bus.adr[gi]};
        end
    endgenerate

    // pos[i] = number of valid clusters ahead of input i, i.e. its slot in the compacted list.
    // Slot 7 can only receive cluster 7 and is never read, since idx stops at n-1 <= 6.
    always_comb begin
        pos       = '0;
        stage_cap = '0;
        for (int i = 1; i < 8; i++) begin
            pos[i] = pos[i-1] + {3'b000, valid[i-1]};
        end
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                if (valid[i] && pos[i] == 4'(j)) begin
                    stage_cap[j] = cluster_word[i];
                end
            end
        end
    end

    assign n_cnt      = pos[7];
    assign trunc      = &valid;
    assign hdr_bxn    = bus.bc0 ? 8'd0 : bxn_reg;
    assign header     = {1'b1, bus.bc0, ovf_pend_reg, trunc, n_cnt, hdr_bxn};
    assign free_words = 16'(DEPTH) - 16'(count_reg);
    assign needed     = 16'(n_cnt) + 16'd1;
    assign pop        = (count_reg != '0);

    // A strobe always wins over the staged write, which is how an overrun BX gets abandoned.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wr_en      = 1'b0;
        wr_data    = 16'h0000;
        hdr_wr     = 1'b0;
        drop       = 1'b0;
        sync_hit   = 1'b0;
        if (bus.frame_strobe) begin
            sync_hit = (state_reg == ST_WRITE);
            if (free_words >= needed) begin
                wr_en      = 1'b1;
                wr_data    = header;
                hdr_wr     = 1'b1;
                idx_next   = 3'd0;
                state_next = (n_cnt != 4'd0) ? ST_WRITE : ST_IDLE;
            end else begin
                drop       = 1'b1;
                state_next = ST_IDLE;
            end
        end else if (state_reg == ST_WRITE) begin
            wr_en    = 1'b1;
            wr_data  = stage_reg[idx_reg];
            idx_next = idx_reg + 3'd1;
            if ({1'b0, idx_reg} == n_reg - 4'd1) begin
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 3'd0;
            n_reg        <= 4'd0;
            stage_reg    <= '0;
            bxn_reg      <= 8'd0;
            ovf_pend_reg <= 1'b0;
            overflow_reg <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (hdr_wr) begin
                stage_reg <= stage_cap;
                n_reg     <= n_cnt;
            end
            if (bus.frame_strobe) begin
                bxn_reg <= bus.bc0 ? 8'd1 : bxn_reg + 8'd1;
            end
            if (drop) begin
                ovf_pend_reg <= 1'b1;
                overflow_reg <= 1'b1;
            end else if (hdr_wr) begin
                ovf_pend_reg <= 1'b0;
            end
            if (sync_hit) begin
                sync_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock4x) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            link_data_reg <= IDLE_WORD;
            link_k_reg    <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                link_data_reg <= mem[rd_ptr_reg];
                link_k_reg    <= 1'b0;
            end else begin
                link_data_reg <= IDLE_WORD;
                link_k_reg    <= 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef FRAMER_DROP_COUNTER_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            drop_cnt_reg <= 16'h0000;
        end else if (drop && drop_cnt_reg != 16'hFFFF) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_reg;
`else
    assign bus.drop_cnt = 16'h0000;
`endif

    assign bus.link_data = link_data_reg;
    assign bus.link_k    = link_k_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.sync_err  = sync_err_reg;
endmodule

// File: tb/tb_cluster_frame_builder.sv
// Directed bench: a default-depth framer for framing/timing, plus a 4-word framer to force BX drops.
module tb_cluster_frame_builder;
    logic clock4x = 1'b0;
    always #3 clock4x = ~clock4x;

    logic             global_reset = 1'b1;
    logic             st = 1'b0;
    logic             b0 = 1'b0;
    logic             sel = 1'b0;
    logic [7:0][10:0] adr_v;
    logic [7:0][2:0]  cnt_v;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    cluster_frame_builder_if fb();
    cluster_frame_builder_if fs();

    assign fb.frame_strobe = st & ~sel;
    assign fb.bc0          = b0;
    assign fb.adr          = adr_v;
    assign fb.cnt          = cnt_v;
    assign fs.frame_strobe = st & sel;
    assign fs.bc0          = b0;
    assign fs.adr          = adr_v;
    assign fs.cnt          = cnt_v;

    cluster_frame_builder u_wide (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .bus          (fb)
    );

    cluster_frame_builder #(.FIFO_AW(2)) u_small (
        .clock4x      (clock4x),
        .global_reset (global_reset),
        .bus          (fs)
    );

    logic [16:0] log_w [8192];
    logic [16:0] log_s [8192];

    always @(posedge clock4x) cyc <= cyc + 1;

    always @(negedge clock4x) begin
        if (cyc < 8192) begin
            log_w[cyc] = {fb.link_k, fb.link_data};
            log_s[cyc] = {fs.link_k, fs.link_data};
        end
    end

    localparam logic [16:0] IDLE = {1'b1, 16'h50BC};

`ifdef FRAMER_DROP_COUNTER_EN
    localparam logic [15:0] EXP_DROPS = 16'd1;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    logic [15:0] exp_all7 [8];
    logic [15:0] exp_hdr;
    int n0, n4, n5, n6, n7, n8, nd, tmp;
    int hn [300];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock4x);
        #1;
    endtask

    // Strobe is driven for the current cycle; returns one cycle later with the strobe cycle index.
    task automatic send(input logic bc, output int n);
        st = 1'b1;
        b0 = bc;
        n  = cyc;
        tick();
        st = 1'b0;
        b0 = 1'b0;
    endtask

    task automatic set_none();
        for (int i = 0; i < 8; i++) begin
            adr_v[i] = 11'd2047;
            cnt_v[i] = 3'd0;
        end
    endtask

    task automatic set_all7();
        for (int i = 0; i < 8; i++) begin
            adr_v[i] = 11'(100 + i);
            cnt_v[i] = 3'(i);
        end
    endtask

    initial begin
        exp_all7 = '{16'h0064, 16'h0865, 16'h1066, 16'h1867,
                     16'h2068, 16'h2869, 16'h306A, 16'h0000};
        set_none();
        repeat (4) tick();
        global_reset = 1'b0;
        repeat (6) tick();

        // Reset state: idle words and clear flags
        for (int i = 1; i <= 4; i++) begin
            check_eq("rst_idle_wide", log_w[cyc-i], IDLE);
            check_eq("rst_idle_small", log_s[cyc-i], IDLE);
        end
        check_eq("rst_overflow", fb.overflow, 1'b0);
        check_eq("rst_sync_err", fb.sync_err, 1'b0);
        check_eq("rst_drop_cnt", fb.drop_cnt, 16'h0000);

        // Two valid clusters with bc0, one invalid tail
        set_none();
        adr_v[0] = 11'd5;    cnt_v[0] = 3'd2;
        adr_v[1] = 11'd1535; cnt_v[1] = 3'd7;
        send(1'b1, n0);
        repeat (6) tick();
        check_eq("bx1_n1_idle", log_w[n0+1], IDLE);
        check_eq("bx1_header", log_w[n0+2], {1'b0, 16'hC200});
        check_eq("bx1_clu0", log_w[n0+3], {1'b0, 16'h1005});
        check_eq("bx1_clu1", log_w[n0+4], {1'b0, 16'h3DFF});
        check_eq("bx1_tail_idle", log_w[n0+5], IDLE);

        // 300 empty BXs spaced 8 cycles; bxn wraps after 255
        set_none();
        for (int i = 0; i < 300; i++) begin
            send(i == 0, hn[i]);
            repeat (7) tick();
        end
        repeat (4) tick();
        for (int i = 0; i < 300; i++) begin
            exp_hdr = (i == 0) ? 16'hC000 : (16'h8000 | 16'(i % 256));
            check_eq($sformatf("bxn_hdr_%0d", i), log_w[hn[i]+2], {1'b0, exp_hdr});
            check_eq($sformatf("bxn_gap_%0d", i), log_w[hn[i]+3], IDLE);
        end

        // All 8 valid: truncated header, clusters 0..6 only (bxn now 44)
        set_all7();
        send(1'b0, n4);
        repeat (10) tick();
        check_eq("all8_header", log_w[n4+2], {1'b0, 16'h972C});
        for (int k = 0; k < 7; k++) begin
            check_eq($sformatf("all8_clu%0d", k), log_w[n4+3+k], {1'b0, exp_all7[k]});
        end
        check_eq("all8_no_adr7", log_w[n4+10], IDLE);

        // Back-to-back strobes on the deep FIFO: sync error but no drop
        check_eq("sync_pre", fb.sync_err, 1'b0);
        set_none();
        adr_v[0] = 11'd10; cnt_v[0] = 3'd1;
        adr_v[1] = 11'd20; cnt_v[1] = 3'd3;
        send(1'b0, n5);
        set_none();
        send(1'b0, tmp);
        check_eq("sync_err_set", fb.sync_err, 1'b1);
        check_eq("sync_no_overflow", fb.overflow, 1'b0);
        repeat (4) tick();
        check_eq("sync_hdr_p", log_w[n5+2], {1'b0, 16'h822D});
        check_eq("sync_hdr_q", log_w[n5+3], {1'b0, 16'h802E});
        check_eq("sync_abandon", log_w[n5+4], IDLE);

        // 4-word FIFO: second BX of 3 clusters does not fit and is dropped
        sel = 1'b1;
        check_eq("small_ovf_pre", fs.overflow, 1'b0);
        set_none();
        for (int i = 0; i < 3; i++) begin
            adr_v[i] = 11'(i + 1);
        end
        send(1'b1, n6);
        send(1'b0, tmp);
        set_none();
        send(1'b0, tmp);
        check_eq("small_overflow", fs.overflow, 1'b1);
        check_eq("small_sync_err", fs.sync_err, 1'b1);
        check_eq("small_drop_cnt", fs.drop_cnt, EXP_DROPS);
        check_eq("wide_overflow_clear", fb.overflow, 1'b0);
        check_eq("wide_drop_cnt", fb.drop_cnt, 16'h0000);
        repeat (7) tick();
        send(1'b0, nd);
        repeat (4) tick();
        check_eq("small_hdr_a", log_s[n6+2], {1'b0, 16'hC300});
        check_eq("small_gap", log_s[n6+3], IDLE);
        check_eq("small_hdr_ovfpend", log_s[n6+4], {1'b0, 16'hA002});
        check_eq("small_after_c", log_s[n6+5], IDLE);
        check_eq("small_hdr_cleared", log_s[nd+2], {1'b0, 16'h8003});
        sel = 1'b0;

        // Reset three cycles into a 7-cluster BX
        set_all7();
        send(1'b0, n7);
        tick();
        tick();
        global_reset = 1'b1;
        tick();
        global_reset = 1'b0;
        check_eq("mid_rst_overflow", fb.overflow, 1'b0);
        check_eq("mid_rst_sync_err", fb.sync_err, 1'b0);
        check_eq("mid_rst_drop_cnt", fb.drop_cnt, 16'h0000);
        check_eq("mid_rst_small_ovf", fs.overflow, 1'b0);
        repeat (4) tick();
        check_eq("mid_rst_hdr", log_w[n7+2], {1'b0, 16'h972F});
        check_eq("mid_rst_clu0", log_w[n7+3], {1'b0, 16'h0064});
        for (int k = 4; k < 8; k++) begin
            check_eq($sformatf("mid_rst_idle_%0d", k), log_w[n7+k], IDLE);
        end
        set_none();
        send(1'b0, n8);
        repeat (4) tick();
        check_eq("post_rst_bxn0", log_w[n8+2], {1'b0, 16'h8000});
        check_eq("post_rst_idle", log_w[n8+3], IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cluster_frame_builder.md
# cluster_frame_builder

Downstream stage of the 8-cluster finder. On every bunch-crossing strobe it captures the 8 address/count pairs and drops invalid clusters, address ≥ 1536. It writes a header word plus up to 7 valid cluster words into a 16-bit word FIFO. It drains one word per clock4x cycle onto the optical-link data path and fills idle cycles with K-flagged idle words.

## Interface
- FIFO_AW, 5: FIFO address width; depth = 2^FIFO_AW words (32).
- IDLE_WORD, 16'h50BC: word driven when the FIFO is empty; emitted with link_k=1.
- clock4x  in  1  160 MHz clock; all logic on its rising edge.
- global_reset  in  1  synchronous, active-high reset.
- frame_strobe  in  1  one-cycle pulse when adr0..7/cnt0..7 are freshly valid; nominally every 8 cycles.
- bc0  in  1  bunch-crossing-zero marker; sampled only with frame_strobe.
- adr0..adr7  in  11 each  cluster addresses, priority order 0 first.
- cnt0..cnt7  in  3 each  cluster sizes.
- link_data  out  16  link word.
- link_k  out  1  1 = idle/control word, 0 = data word.
- overflow  out  1  sticky; a BX was dropped for lack of FIFO space.
- sync_err  out  1  sticky; a frame_strobe arrived while the previous BX was still being written.
- drop_cnt  out  16  count of dropped BXs (see Configuration).

## Operation
- Valid cluster: adr < 11'd1536.
- n = number of valid clusters among 0..6, capped at 7.
- trunc = 1 when all 8 inputs are valid. Cluster 7 is never sent.
- Header word: [15]=1, [14]=bc0, [13]=ovf_pend, [12]=trunc, [11:8]=n, [7:0]=bxn.
- Cluster word: [15:14]=2'b00, [13:11]=cnt, [10:0]=adr.
- bxn, 8-bit counter:
  - On a strobe with bc0=1, the header carries bxn=0 and the counter becomes 1.
  - Otherwise the header carries the current bxn, and bxn increments with wrap 255→0.
- Writer FSM, states IDLE and WRITE:
  - IDLE + strobe: capture the valid clusters into a compacted staging list. If free ≥ 1+n, write the header this cycle and go to WRITE when n>0. Otherwise drop the whole BX: write nothing, set overflow and ovf_pend, increment drop_cnt.
  - WRITE: write one staged cluster per cycle in ascending input index. Return to IDLE after the n-th cluster.
- ovf_pend is cleared by the next successfully written header.
- A strobe while in WRITE:
  - Set sync_err.
  - Abandon the remaining staged clusters.
  - Process the new strobe exactly as from IDLE.
- Reader: every cycle the FIFO is non-empty, pop one word and output it with link_k=0. Otherwise output IDLE_WORD with link_k=1.
- Simultaneous FIFO write and read is always allowed. Free-space accounting uses occupancy before this cycle's pop.
- Reset values: link_data=IDLE_WORD, link_k=1, overflow=0, sync_err=0, drop_cnt=0, bxn=0, ovf_pend=0, FIFO empty, FSM=IDLE.
- Reset mid-BX discards all staged and queued words.

## Timing
- Strobe in cycle N, FIFO empty: header on link_data in cycle N+2, cluster k (k=1..n) in cycle N+2+k.
- Worst case throughput is 8 words per 8 cycles, which matches the drain rate. With nominal strobe spacing the FIFO never grows beyond one BX.
- overflow, sync_err and drop_cnt update in the cycle after the offending strobe. overflow and sync_err clear only on reset.
- Full: occupancy 2^FIFO_AW. Writes never exceed full, because the drop decision reserves the whole BX up front.
- Empty: the reader emits idle with no bubble between back-to-back BXs.

## Configuration
- FRAMER_DROP_COUNTER_EN defined: drop_cnt is a 16-bit counter, incremented per dropped BX, saturating at 16'hFFFF.
- Not defined: drop_cnt is constant 0 and no counter logic is built. overflow is unaffected.

## Test plan
- Reset, no strobes: link_data=16'h50BC with link_k=1 every cycle. overflow=0, sync_err=0.
- Strobe with bc0=1, adr0=5/cnt0=2, adr1=1535/cnt1=7, adr2..7=2047: link in cycles N+2..N+4 = 16'hC200, 16'h1005, 16'h3DFF, then idle.
- 300 strobes spaced 8 cycles, bc0 only on the first, no clusters: header bxn sequence 0,1,…,255,0,…. Every header has n=0. Idle fills the gaps.
- Strobe with all 8 clusters valid: header trunc=1, n=7. Clusters 0..6 in order. adr7 never appears.
- Hold the reader inactive by filling the FIFO with strobes spaced 1 cycle: sync_err=1. When free < 1+n, the BX is dropped, overflow=1, drop_cnt increments, and the next written header has bit 13 set.
- global_reset asserted 3 cycles into a 7-cluster BX: the next cycle shows idle, all counters and flags are 0, and the next strobe's header has bxn=0.
